// File: rtl/tomasulo_core.sv
// tomasulo_core: Tomasulo OoO core, 3 add + 3 mul RS, 8-entry ROB, 16x8b regs.
// In: clk1, rst_n (sync, low), pc/issue_valid, imem_we/waddr/wdata.
// Out: stall, commit_valid/rd/value, rob_empty.
// DEBUG_READ_EN adds dbg_raddr -> dbg_rdata (comb read of regs).
module tomasulo_core #(
  parameter int XLEN      = 8,
  parameter int ROB_DEPTH = 8,
  parameter int MUL_LAT   = 3
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic [3:0]      pc,
  input  logic            issue_valid,
  input  logic            imem_we,
  input  logic [3:0]      imem_waddr,
  input  logic [15:0]     imem_wdata,
  output logic            stall,
  output logic            commit_valid,
  output logic [3:0]      commit_rd,
  output logic [XLEN-1:0] commit_value,
  output logic            rob_empty
`ifdef DEBUG_READ_EN
  ,
  input  logic [3:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
`endif
);
  localparam int TW  = $clog2(ROB_DEPTH);
  localparam int CW  = $clog2(MUL_LAT + 1);
  localparam int NRS = 3;
  localparam logic [TW:0] FULL = (TW+1)'(ROB_DEPTH);

  typedef struct packed {
    logic            busy;
    logic            r1;
    logic            r2;
    logic [TW-1:0]   q1;
    logic [TW-1:0]   q2;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic [TW-1:0]   dst;
  } rs_t;

  typedef struct packed {
    logic            rdy;
    logic [TW-1:0]   q;
    logic [XLEN-1:0] v;
  } opnd_t;

  logic [15:0]     imem [16];
  logic [XLEN-1:0] regs [16];
  logic            stv [16];
  logic [TW-1:0]   stt [16];
  logic [3:0]      rob_rd [ROB_DEPTH];
  logic [XLEN-1:0] rob_val [ROB_DEPTH];
  logic            rob_done [ROB_DEPTH];
  logic [TW-1:0]   head, tail;
  logic [TW:0]     count;
  rs_t             ars [NRS];
  rs_t             mrs [NRS];
  rs_t             ars_w [NRS];
  rs_t             mrs_w [NRS];
  logic            asub [NRS];
  logic            a_v;
  logic [TW-1:0]   a_tag;
  logic [XLEN-1:0] a_res;
  logic            m_busy;
  logic [CW-1:0]   m_cnt;
  logic [TW-1:0]   m_tag;
  logic [XLEN-1:0] m_res;
  logic            mw;

  logic [15:0] ins;
  logic [1:0]  op;
  logic [3:0]  rd, s1, s2, crd;
  logic        is_mul, is_nop, stall_c, do_iss, do_com;
  logic        af_ok, mf_ok, ad_ok, md_ok;
  logic [1:0]  af, mf, ad, md;
  opnd_t       op1, op2;
  rs_t         ns;
  logic        unused_ign;

  assign ins        = imem[pc];
  assign op         = ins[15:14];
  assign rd         = ins[11:8];
  assign s1         = ins[7:4];
  assign s2         = ins[3:0];
  assign unused_ign = ^ins[13:12];
  assign is_mul     = (op == 2'b10);
  assign is_nop     = (op == 2'b11);
  assign mw         = m_busy && (m_cnt == '0);
  assign rob_empty  = (count == '0);
  assign crd        = rob_rd[head];
  assign do_com     = !rob_empty && rob_done[head];

  // Bus forwarding first, then a finished ROB entry, else wait on tag.
  function automatic opnd_t fetch(input logic [3:0] r);
    opnd_t o;
    o.rdy = 1'b1;
    o.q   = stt[r];
    o.v   = regs[r];
    if (stv[r]) begin
      if (a_v && a_tag == o.q) begin
        o.v = a_res;
      end else if (mw && m_tag == o.q) begin
        o.v = m_res;
      end else if (rob_done[o.q]) begin
        o.v = rob_val[o.q];
      end else begin
        o.rdy = 1'b0;
      end
    end
    return o;
  endfunction

  function automatic rs_t wake(input rs_t s);
    rs_t w;
    w = s;
    if (!s.r1 && a_v && s.q1 == a_tag) begin
      w.r1 = 1'b1; w.v1 = a_res;
    end
    if (!s.r1 && mw && s.q1 == m_tag) begin
      w.r1 = 1'b1; w.v1 = m_res;
    end
    if (!s.r2 && a_v && s.q2 == a_tag) begin
      w.r2 = 1'b1; w.v2 = a_res;
    end
    if (!s.r2 && mw && s.q2 == m_tag) begin
      w.r2 = 1'b1; w.v2 = m_res;
    end
    return w;
  endfunction

  always_comb begin
    op1 = fetch(s1);
    op2 = fetch(s2);
    ns  = '{busy: 1'b1, r1: op1.rdy, r2: op2.rdy,
            q1: op1.q, q2: op2.q, v1: op1.v, v2: op2.v,
            dst: tail};
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    af_ok = 1'b0; af = '0;
    mf_ok = 1'b0; mf = '0;
    ad_ok = 1'b0; ad = '0;
    md_ok = 1'b0; md = '0;
    for (int i = NRS - 1; i >= 0; i--) begin
      ars_w[i] = wake(ars[i]);
      mrs_w[i] = wake(mrs[i]);
      if (!ars[i].busy) begin af_ok = 1'b1; af = 2'(i); end
      if (!mrs[i].busy) begin mf_ok = 1'b1; mf = 2'(i); end
      if (ars[i].busy && ars[i].r1 && ars[i].r2) begin
        ad_ok = 1'b1; ad = 2'(i);
      end
      if (mrs[i].busy && mrs[i].r1 && mrs[i].r2) begin
        md_ok = 1'b1; md = 2'(i);
      end
    end
    // The multiplier accepts new work in its final busy cycle.
    md_ok = md_ok && (!m_busy || mw);
  end

  assign stall_c = !is_nop &&
                   (count == FULL || (is_mul ? !mf_ok : !af_ok));
  assign stall   = issue_valid && stall_c;
  assign do_iss  = issue_valid && !is_nop && !stall_c;

  always_ff @(posedge clk1) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        regs[k] <= XLEN'(k);
        stv[k]  <= 1'b0;
        stt[k]  <= '0;
      end
      for (int k = 0; k < ROB_DEPTH; k++) rob_done[k] <= 1'b0;
      for (int k = 0; k < NRS; k++) begin
        ars[k]  <= '0;
        mrs[k]  <= '0;
        asub[k] <= 1'b0;
      end
      head <= '0; tail <= '0; count <= '0;
      a_v <= 1'b0; a_tag <= '0; a_res <= '0;
      m_busy <= 1'b0; m_cnt <= '0; m_tag <= '0; m_res <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
    end else begin
      if (a_v) begin
        rob_done[a_tag] <= 1'b1;
        rob_val[a_tag]  <= a_res;
      end
      if (mw) begin
        rob_done[m_tag] <= 1'b1;
        rob_val[m_tag]  <= m_res;
      end
      for (int k = 0; k < NRS; k++) begin
        ars[k] <= ars_w[k];
        mrs[k] <= mrs_w[k];
      end
      a_v <= ad_ok;
      if (ad_ok) begin
        ars[ad].busy <= 1'b0;
        a_tag <= ars[ad].dst;
        a_res <= asub[ad] ? ars[ad].v1 - ars[ad].v2
                          : ars[ad].v1 + ars[ad].v2;
      end
      if (md_ok) begin
        mrs[md].busy <= 1'b0;
        m_busy <= 1'b1;
        m_cnt  <= CW'(MUL_LAT - 1);
        m_tag  <= mrs[md].dst;
        m_res  <= mrs[md].v1 * mrs[md].v2;
      end else if (m_busy) begin
        if (mw) m_busy <= 1'b0;
        else    m_cnt  <= m_cnt - 1'b1;
      end
      commit_valid <= do_com;
      if (do_com) begin
        regs[crd] <= rob_val[head];
        if (stv[crd] && stt[crd] == head) stv[crd] <= 1'b0;
        head         <= head + 1'b1;
        commit_rd    <= crd;
        commit_value <= rob_val[head];
      end
      // Issued after commit so a fresh tag on the same rd survives.
      if (do_iss) begin
        rob_rd[tail]   <= rd;
        rob_done[tail] <= 1'b0;
        stv[rd]        <= 1'b1;
        stt[rd]        <= tail;
        tail           <= tail + 1'b1;
        if (is_mul) begin
          mrs[mf] <= ns;
        end else begin
          ars[af]  <= ns;
          asub[af] <= (op == 2'b01);
        end
      end
      count <= count + {{TW{1'b0}}, do_iss} - {{TW{1'b0}}, do_com};
    end
  end

`ifdef DEBUG_READ_EN
  assign dbg_rdata = regs[dbg_raddr];
`endif

endmodule

// File: tb/tb_tomasulo_core.sv
// tb_tomasulo_core: vector table + hand sequences, commit scoreboard.
// Expected commits queued at issue, popped by the commit monitor.
module tb_tomasulo_core;
  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pc = '0;
  logic        issue_valid = 1'b0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [15:0] imem_wdata = '0;
  logic        stall, commit_valid, rob_empty;
  logic [3:0]  commit_rd;
  logic [7:0]  commit_value;
`ifdef DEBUG_READ_EN
  logic [3:0]  dbg_raddr = '0;
  logic [7:0]  dbg_rdata;
`endif

  tomasulo_core dut (
    .clk1(clk1), .rst_n(rst_n), .pc(pc), .issue_valid(issue_valid),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .stall(stall), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .rob_empty(rob_empty)
`ifdef DEBUG_READ_EN
    , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`endif
  );

  always #5 clk1 = ~clk1;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, NOP = 2'd3;

  typedef struct packed { logic [3:0] rd; logic [7:0] v; } exp_t;
  typedef struct {
    logic [1:0] op;
    logic [3:0] rd, rs1, rs2;
    logic [1:0] ign;
    logic [7:0] val;
    int         lat;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op,
    input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] ign);
    return {op, ign, rd, a, b};
  endfunction

  always @(negedge clk1) begin : mon
    exp_t e;
    if (rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious commit", int'(commit_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("commit rd", int'(commit_rd), int'(e.rd));
        chk("commit value", int'(commit_value), int'(e.v));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] w);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = w;
    @(negedge clk1);
    imem_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] p, input logic [3:0] erd,
                       input logic [7:0] ev, output logic saw);
    int   n;
    exp_t x;
    saw = 1'b0;
    pc = p;
    issue_valid = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin
      saw = 1'b1;
      @(negedge clk1);
      #1;
      n++;
    end
    if (stall) chk("issue stall timeout", int'(stall), 0);
    x.rd = erd; x.v = ev;
    exp_q.push_back(x);
    @(negedge clk1);
    issue_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk1);
      n++;
    end
    chk({nm, " drain"}, exp_q.size(), 0);
    chk({nm, " rob_empty"}, int'(rob_empty), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    logic saw;
    int   cyc, first;

    vt[0] = '{ADD, 4'd1,  4'd2,  4'd3,  2'd0, 8'd5,   3};
    vt[1] = '{MUL, 4'd4,  4'd5,  4'd6,  2'd0, 8'd30,  5};
    vt[2] = '{SUB, 4'd0,  4'd2,  4'd3,  2'd0, 8'd255, 3};
    vt[3] = '{ADD, 4'd15, 4'd15, 4'd15, 2'd3, 8'd30,  3};
    vt[4] = '{MUL, 4'd14, 4'd15, 4'd15, 2'd2, 8'd225, 5};
    vt[5] = '{SUB, 4'd9,  4'd9,  4'd9,  2'd1, 8'd0,   3};
    vt[6] = '{MUL, 4'd12, 4'd13, 4'd14, 2'd0, 8'd182, 5};
    vt[7] = '{SUB, 4'd3,  4'd14, 4'd13, 2'd0, 8'd1,   3};
    vt[8] = '{ADD, 4'd7,  4'd0,  4'd0,  2'd0, 8'd0,   3};
    vt[9] = '{MUL, 4'd2,  4'd15, 4'd9,  2'd0, 8'd135, 5};

    do_reset();
    chk("reset rob_empty", int'(rob_empty), 1);
    chk("reset commit_valid", int'(commit_valid), 0);
    chk("reset stall", int'(stall), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      load(4'd0, mk(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].ign));
      issue(4'd0, vt[i].rd, vt[i].val, saw);
      chk($sformatf("vec%0d stalled", i), int'(saw), 0);
      cyc = 0;
      while (!commit_valid && cyc < 30) begin
        @(negedge clk1);
        cyc++;
      end
      chk($sformatf("vec%0d latency", i), cyc, vt[i].lat);
      @(negedge clk1);
      chk($sformatf("vec%0d rob_empty", i), int'(rob_empty), 1);
    end

    // Dependency chain: ADD feeds MUL, MUL feeds MUL.
    do_reset();
    load(4'd0, mk(ADD, 4'd1,  4'd2,  4'd3,  2'd0));
    load(4'd1, mk(MUL, 4'd7,  4'd1,  4'd1,  2'd0));
    load(4'd2, mk(MUL, 4'd14, 4'd15, 4'd15, 2'd0));
    load(4'd3, mk(MUL, 4'd13, 4'd14, 4'd14, 2'd0));
    issue(4'd0, 4'd1,  8'd5,   saw);
    issue(4'd1, 4'd7,  8'd25,  saw);
    issue(4'd2, 4'd14, 8'd225, saw);
    issue(4'd3, 4'd13, 8'd193, saw);
    drain("dep");

    // Reset after activity clears the commit outputs.
    do_reset();
    chk("re-reset commit_rd", int'(commit_rd), 0);
    chk("re-reset commit_value", int'(commit_value), 0);
    chk("re-reset rob_empty", int'(rob_empty), 1);
    pc = 4'd3;
    issue_valid = 1'b1;
    #1;
    chk("re-reset stall", int'(stall), 0);
    issue_valid = 1'b0;
    @(negedge clk1);

    // ROB fill: MUL chain holds the head while ADDs pile up.
    do_reset();
    load(4'd0, mk(MUL, 4'd4, 4'd5, 4'd6, 2'd0));
    load(4'd1, mk(MUL, 4'd7, 4'd4, 4'd2, 2'd0));
    load(4'd2, mk(MUL, 4'd8, 4'd7, 4'd2, 2'd0));
    for (int i = 0; i < 9; i++)
      load(4'(3 + i), mk(ADD, 4'(9 + i % 7), 4'(i % 4), 4'd5, 2'd0));
    issue(4'd0, 4'd4, 8'd30,  saw);
    issue(4'd1, 4'd7, 8'd60,  saw);
    issue(4'd2, 4'd8, 8'd120, saw);
    first = 0;
    for (int i = 0; i < 9; i++) begin
      issue(4'(3 + i), 4'(9 + i % 7), 8'(i % 4 + 5), saw);
      if (saw && first == 0) first = i + 1;
    end
    chk("first full-ROB stall add", first, 7);
    drain("fill");

    // Mul RS exhaustion with independent MULs.
    load(4'd0, mk(MUL, 4'd4,  4'd5, 4'd6, 2'd0));
    load(4'd1, mk(MUL, 4'd9,  4'd2, 4'd3, 2'd0));
    load(4'd2, mk(MUL, 4'd10, 4'd3, 4'd3, 2'd0));
    load(4'd3, mk(MUL, 4'd11, 4'd5, 4'd2, 2'd0));
    load(4'd4, mk(MUL, 4'd12, 4'd6, 4'd6, 2'd0));
    first = 0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: issue(4'd0, 4'd4,  8'd30, saw);
        1: issue(4'd1, 4'd9,  8'd6,  saw);
        2: issue(4'd2, 4'd10, 8'd9,  saw);
        3: issue(4'd3, 4'd11, 8'd10, saw);
        default: issue(4'd4, 4'd12, 8'd36, saw);
      endcase
      if (saw && first == 0) first = i + 1;
    end
    chk("first mul RS stall", first, 5);
    drain("mulrs");

    // NOP never stalls and never allocates.
    load(4'd5, mk(NOP, 4'd1, 4'd2, 4'd3, 2'd0));
    pc = 4'd5;
    issue_valid = 1'b1;
    #1;
    chk("nop stall", int'(stall), 0);
    repeat (4) @(negedge clk1);
    chk("nop rob_empty", int'(rob_empty), 1);
    issue_valid = 1'b0;

    // Reset with MULs in flight.
    load(4'd6, mk(ADD, 4'd1, 4'd4, 4'd0, 2'd0));
    load(4'd7, mk(MUL, 4'd9, 4'd5, 4'd5, 2'd0));
    issue(4'd0, 4'd4, 8'd30, saw);
    issue(4'd1, 4'd9, 8'd6,  saw);
    do_reset();
    repeat (10) @(negedge clk1);
    chk("flush rob_empty", int'(rob_empty), 1);
    pc = 4'd0;
    issue_valid = 1'b1;
    #1;
    chk("flush stall", int'(stall), 0);
    issue_valid = 1'b0;
    @(negedge clk1);
    issue(4'd6, 4'd1, 8'd4,  saw);
    issue(4'd7, 4'd9, 8'd25, saw);
    drain("flush");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
